// File: rtl/ysyx_25050147_mem_pkg.sv
// Shared types and helpers for the multi-cycle memory responder.
// FSM states, request bundle, delay width and byte-lane merge.
package ysyx_25050147_mem_pkg;

    localparam int DLY_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_25050147_mem_responder_lfsr8.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Advances only when enabled; resets asynchronously to the seed.
module ysyx_25050147_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [7:0] q_o
);

    localparam logic [7:0] TAPS = 8'hB8;

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ TAPS;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/ysyx_25050147_mem_responder.sv
// Multi-cycle memory responder: one request at a time, fixed or
// pseudo-random delay, word-addressed SRAM behind a response channel.
module ysyx_25050147_mem_responder
    import ysyx_25050147_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 0,
    parameter bit          RAND_DLY    = 1'b0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int               AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0]      SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [DLY_W-1:0] LAT_C = DLY_W'(LATENCY);

    state_e           state_q;
    logic [DLY_W-1:0] cnt_q;
    mem_req_t         req_q;
    logic             rsp_valid_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [7:0]       lfsr;
    logic             accept;
    logic [DLY_W-1:0] dly;
    logic             enter_resp;
    mem_req_t         in_req;
    mem_req_t         acc;
    logic [31:0]      off;
    logic             in_rng;
    logic [AW-1:0]    idx;
    logic [31:0]      rd_word;
    logic             do_write;
    logic [31:0]      rdata_d;
    logic             unused_bits;

    assign req_ready = rst & (state_q == IDLE);
    assign accept    = req_valid & req_ready;

    ysyx_25050147_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (accept),
        .q_o    (lfsr)
    );

    assign dly = RAND_DLY ? lfsr[DLY_W-1:0] : LAT_C;

    assign in_req = '{
        wen:   req_wen,
        addr:  req_addr,
        wdata: req_wdata,
        wmask: req_wmask[3:0]
    };

    // Zero-delay requests hit the array in the accept cycle itself,
    // before the latched copy exists, so take the live request then.
    assign acc = (state_q == IDLE) ? in_req : req_q;

    assign enter_resp = ((state_q == IDLE) && accept && (dly == '0))
                      || ((state_q == WAIT) && (cnt_q == DLY_W'(1)));

    assign off    = acc.addr - ADDR_BASE;
    assign in_rng = (acc.addr >= ADDR_BASE) && ({1'b0, off} < SPAN);
    assign idx    = off[AW+1:2];

    assign rd_word  = mem_q[idx];
    assign do_write = enter_resp & acc.wen & in_rng;
    assign rdata_d  = (!acc.wen && in_rng) ? rd_word : 32'h0;

    assign unused_bits = ^{off[31:AW+2], off[1:0], req_wmask[7:4],
                           lfsr[7:DLY_W]};

    // Array is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[idx] <= merge_bytes(mem_q[idx], acc.wdata, acc.wmask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q <= in_req;
                        cnt_q <= dly;
                        if (dly == '0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= rdata_d;
                            err_q       <= ~in_rng;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - DLY_W'(1);
                    if (enter_resp) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= rdata_d;
                        err_q       <= ~in_rng;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rdata_q     <= 32'h0;
                        err_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25050147_mem_responder.sv
// Directed, table-driven and randomized checks of the memory responder
// in fixed-zero, fixed-three and random delay configurations.
module tb_ysyx_25050147_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        rv    [3];
    logic        rr    [3];
    logic        rw    [3];
    logic [31:0] ra    [3];
    logic [31:0] rwd   [3];
    logic [7:0]  rm    [3];
    logic        rsv   [3];
    logic        ry    [3];
    logic [31:0] rsd   [3];
    logic        rse   [3];

    int checks = 0;
    int errors = 0;

    ysyx_25050147_mem_responder #(.LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst_n[0]), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_wen(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
        .req_wmask(rm[0]), .rsp_valid(rsv[0]), .rsp_ready(ry[0]),
        .rsp_rdata(rsd[0]), .rsp_err(rse[0])
    );

    ysyx_25050147_mem_responder #(.LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst_n[1]), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_wen(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
        .req_wmask(rm[1]), .rsp_valid(rsv[1]), .rsp_ready(ry[1]),
        .rsp_rdata(rsd[1]), .rsp_err(rse[1])
    );

    ysyx_25050147_mem_responder #(.RAND_DLY(1'b1)) u_rand (
        .clk(clk), .rst(rst_n[2]), .req_valid(rv[2]), .req_ready(rr[2]),
        .req_wen(rw[2]), .req_addr(ra[2]), .req_wdata(rwd[2]),
        .req_wmask(rm[2]), .rsp_valid(rsv[2]), .rsp_ready(ry[2]),
        .rsp_rdata(rsd[2]), .rsp_err(rse[2])
    );

    typedef struct {
        string       name;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  mask;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input bit c, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!c) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic txn(input int d, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] mask,
                       input int stall, output logic [31:0] rdata,
                       output logic err, output int lat, output bit ok);
        int n;
        ok = 1'b1;
        lat = 0;
        rdata = 32'h0;
        err = 1'b0;
        @(negedge clk);
        rv[d] = 1'b1; rw[d] = wen; ra[d] = addr; rwd[d] = wdata; rm[d] = mask;
        n = 0;
        while (!rr[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rr[d]) begin
            chk(rr[d] == 1'b1, "accept_timeout", 64'(rr[d]), 64'd1);
            rv[d] = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        rv[d] = 1'b0; rw[d] = ~wen; ra[d] = $urandom; rwd[d] = $urandom;
        rm[d] = 8'($urandom);
        lat = 1;
        while (!rsv[d] && lat < 20) begin
            ry[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        ry[d] = 1'b0;
        if (!rsv[d]) begin
            chk(rsv[d] == 1'b1, "rsp_timeout", 64'(rsv[d]), 64'd1);
            ok = 1'b0;
            return;
        end
        rdata = rsd[d];
        err = rse[d];
        for (int i = 0; i < stall; i++) begin
            chk(rsv[d] && !rr[d] && rsd[d] == rdata && rse[d] == err,
                "stall_hold", {rsv[d], rr[d], rse[d], rsd[d]},
                {1'b1, 1'b0, err, rdata});
            @(negedge clk);
        end
        ry[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ry[d] = 1'b0;
        chk(!rsv[d] && rr[d], "post_handshake", {rsv[d], rr[d]}, 64'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;
        logic [31:0] model [16];
        bit          seen [9];
        int          distinct;
        bit          got_rsp;

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = 32'h0;
            rwd[d] = 32'h0; rm[d] = 8'h0; ry[d] = 1'b0;
        end

        vecs.push_back('{"st_base",  1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 8'h0F, 32'h0, 1'b0});
        vecs.push_back('{"st_last",  1'b1, 32'h8000_0FFC, 32'h5566_7788, 8'h0F, 32'h0, 1'b0});
        vecs.push_back('{"st_dead",  1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0});
        vecs.push_back('{"ld_dead",  1'b0, 32'h8000_0010, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"st_fill",  1'b1, 32'h8000_0020, 32'h1122_3344, 8'h0F, 32'h0, 1'b0});
        vecs.push_back('{"st_byte1", 1'b1, 32'h8000_0020, 32'h0000_AA00, 8'hF2, 32'h0, 1'b0});
        vecs.push_back('{"ld_merge", 1'b0, 32'h8000_0020, 32'h0,         8'h00, 32'h1122_AA44, 1'b0});
        vecs.push_back('{"st_nomask",1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 8'hF0, 32'h0, 1'b0});
        vecs.push_back('{"ld_nomask",1'b0, 32'h8000_0020, 32'h0,         8'h00, 32'h1122_AA44, 1'b0});
        vecs.push_back('{"ld_below", 1'b0, 32'h7FFF_FFFC, 32'h0,         8'h00, 32'h0, 1'b1});
        vecs.push_back('{"ld_above", 1'b0, 32'h8000_1000, 32'h0,         8'h00, 32'h0, 1'b1});
        vecs.push_back('{"ld_top",   1'b0, 32'hFFFF_FFFF, 32'h0,         8'h00, 32'h0, 1'b1});
        vecs.push_back('{"st_below", 1'b1, 32'h7FFF_FFFC, 32'hCAFE_F00D, 8'h0F, 32'h0, 1'b1});
        vecs.push_back('{"st_above", 1'b1, 32'h8000_1000, 32'hCAFE_F00D, 8'h0F, 32'h0, 1'b1});
        vecs.push_back('{"ld_base",  1'b0, 32'h8000_0000, 32'h0,         8'h00, 32'hA5A5_A5A5, 1'b0});
        vecs.push_back('{"ld_last",  1'b0, 32'h8000_0FFC, 32'h0,         8'h00, 32'h5566_7788, 1'b0});
        vecs.push_back('{"ld_lastb", 1'b0, 32'h8000_0FFF, 32'h0,         8'h00, 32'h5566_7788, 1'b0});
        vecs.push_back('{"st_unal",  1'b1, 32'h8000_0013, 32'h0102_0304, 8'h09, 32'h0, 1'b0});
        vecs.push_back('{"ld_unal",  1'b0, 32'h8000_0010, 32'h0,         8'h00, 32'h01AD_BE04, 1'b0});

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk(!rr[d] && !rsv[d] && rsd[d] == 32'h0 && !rse[d], "reset_state",
                {rr[d], rsv[d], rse[d], rsd[d]}, 64'h0);
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk(rr[d] == 1'b1, "ready_after_reset", 64'(rr[d]), 64'd1);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            txn(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                i % 3, rd, er, lat, ok);
            if (ok) begin
                chk({er, rd} == {vecs[i].exp_err, vecs[i].exp_rd}, vecs[i].name,
                    {er, rd}, {vecs[i].exp_err, vecs[i].exp_rd});
                chk(lat == 1, "lat0_latency", 64'(lat), 64'd1);
            end
        end

        txn(1, 1'b1, 32'h8000_0000, 32'hAAAA_5555, 8'h0F, 0, rd, er, lat, ok);
        chk(ok && lat == 4 && !er, "lat3_store", {er, 32'(lat)}, 64'd4);
        txn(1, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 5, rd, er, lat, ok);
        chk(ok && lat == 4, "lat3_latency", 64'(lat), 64'd4);
        chk(rd == 32'hAAAA_5555 && !er, "lat3_load", {er, rd}, 64'hAAAA_5555);

        @(negedge clk);
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 32'h8000_0000;
        rwd[1] = 32'h1234_5678; rm[1] = 8'h0F;
        chk(rr[1] == 1'b1, "rst_pre_accept", 64'(rr[1]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rv[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk(!rr[1] && !rsv[1], "rst_mid_wait", {rr[1], rsv[1]}, 64'h0);
        @(negedge clk);
        chk(!rr[1] && !rsv[1], "rst_held", {rr[1], rsv[1]}, 64'h0);
        rst_n[1] = 1'b1;
        got_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsv[1]) got_rsp = 1'b1;
        end
        chk(!got_rsp && rr[1], "rst_no_rsp", {got_rsp, rr[1]}, 64'b01);
        txn(1, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 0, rd, er, lat, ok);
        chk(rd == 32'hAAAA_5555 && !er, "rst_store_dropped", {er, rd}, 64'hAAAA_5555);

        for (int i = 0; i < 9; i++) seen[i] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(2, 1'b1, 32'h8000_0000 + 32'(4 * i), model[i], 8'h0F,
                0, rd, er, lat, ok);
            chk(ok && {er, rd} == 33'h0, "rand_prefill", {er, rd}, 64'h0);
        end
        for (int t = 0; t < 200; t++) begin
            int          sel;
            logic        wen;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [7:0]  m;
            logic [32:0] exp;
            sel = $urandom_range(0, 17);
            wen = 1'($urandom_range(0, 1));
            wd = $urandom;
            m = 8'($urandom);
            if (sel == 16) addr = 32'h8000_1000 + 32'($urandom_range(0, 255));
            else if (sel == 17) addr = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
            else addr = 32'h8000_0000 + 32'(4 * sel) + 32'($urandom_range(0, 3));
            if (sel >= 16) begin
                exp = {1'b1, 32'h0};
            end else if (wen) begin
                exp = 33'h0;
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) model[sel][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                exp = {1'b0, model[sel]};
            end
            txn(2, wen, addr, wd, m, $urandom_range(0, 3), rd, er, lat, ok);
            if (ok) begin
                chk({er, rd} == exp, "rand_data", {er, rd}, exp);
                chk(lat >= 1 && lat <= 8, "rand_latency", 64'(lat), 64'd8);
                if (lat >= 1 && lat <= 8) seen[lat] = 1'b1;
            end
        end
        distinct = 0;
        for (int i = 1; i < 9; i++) if (seen[i]) distinct++;
        chk(distinct >= 4, "rand_latency_spread", 64'(distinct), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
